// File: rtl/rs_dec_pkg.sv
// Shared definitions for the CD C1 Reed-Solomon decode path.
package rs_dec_pkg;

  localparam int unsigned SymbW   = 8;
  localparam int unsigned C1NSymb = 32;
  localparam int unsigned NSynd   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWaitSynd,
    StWaitEuclid,
    StDone
  } state_e;

endpackage

// File: rtl/rs_dec_sat_counter.sv
// Saturating statistics counter with synchronous clear; clear beats increment.
module rs_dec_sat_counter #(
  parameter int unsigned P_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           inc,
  output logic [P_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + P_W'(1);
    end
  end

endmodule

// File: rtl/rs_dec_frame_scheduler.sv
// Frames EFM symbols into the syndrome calculator, launches Euclid only for errored
// codewords, and reports per-codeword status plus saturating statistics.
module rs_dec_frame_scheduler
  import rs_dec_pkg::*;
#(
  parameter int unsigned P_N_SYMB  = C1NSymb,
  parameter int unsigned P_TIMEOUT = 64,
  parameter int unsigned P_CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_resb,
  input  logic [SymbW-1:0]   i_symb,
  input  logic               i_symb_valid,
  input  logic               i_frame_sync,
  output logic               o_synd_frame_sync,
  output logic [SymbW-1:0]   o_synd_data,
  output logic               o_synd_data_sync,
  input  logic               i_synd_ready,
  input  logic [SymbW-1:0]   i_s0,
  input  logic [SymbW-1:0]   i_s1,
  input  logic [SymbW-1:0]   i_s2,
  input  logic [SymbW-1:0]   i_s3,
  output logic               o_euclid_start,
  input  logic               i_euclid_ready,
  output logic               o_cw_done,
  output logic               o_cw_err,
  output logic               o_cw_fail,
  output logic               o_busy,
  output logic               o_overrun,
  input  logic               i_clr_stat,
  output logic [P_CNT_W-1:0] o_cw_cnt,
  output logic [P_CNT_W-1:0] o_err_cnt
);

  localparam int unsigned CntW = $clog2(P_N_SYMB + 1);
  localparam int unsigned TmoW = $clog2(P_TIMEOUT + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(P_N_SYMB - 1);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(P_TIMEOUT);

  state_e                        state_q, state_d;
  logic [CntW-1:0]               symb_cnt_q, symb_cnt_d;
  logic [TmoW-1:0]               tmo_q, tmo_d;
  logic [SymbW-1:0]              synd_data_q, synd_data_d;
  logic                          synd_data_sync_q, synd_data_sync_d;
  logic                          synd_frame_sync_q, synd_frame_sync_d;
  logic                          euclid_start_q, euclid_start_d;
  logic                          cw_done_q, cw_done_d;
  logic                          cw_err_q, cw_err_d;
  logic                          cw_fail_q, cw_fail_d;
  logic                          overrun_q, overrun_d;
  logic                          busy_q;
  logic [NSynd-1:0][SymbW-1:0]   synd;
  logic                          sync_in;
  logic                          synd_zero;
  logic                          timed_out;

  assign synd      = {i_s3, i_s2, i_s1, i_s0};
  assign sync_in   = i_frame_sync & i_symb_valid;
  assign synd_zero = (synd == '0);
  assign timed_out = (tmo_q == TmoMax);

  always_comb begin
    state_d           = state_q;
    symb_cnt_d        = symb_cnt_q;
    tmo_d             = tmo_q + TmoW'(1);
    synd_data_d       = synd_data_q;
    synd_data_sync_d  = 1'b0;
    synd_frame_sync_d = 1'b0;
    euclid_start_d    = 1'b0;
    cw_done_d         = 1'b0;
    cw_err_d          = cw_err_q;
    cw_fail_d         = cw_fail_q;
    overrun_d         = overrun_q;

    case (state_q)
      StIdle: begin
        if (sync_in) begin
          synd_data_d       = i_symb;
          synd_data_sync_d  = 1'b1;
          synd_frame_sync_d = 1'b1;
          symb_cnt_d        = CntW'(1);
          state_d           = StCollect;
        end
      end
      StCollect: begin
        if (i_symb_valid) begin
          synd_data_d      = i_symb;
          synd_data_sync_d = 1'b1;
          if (i_frame_sync) begin
            // Early sync: close the short codeword as failed and restart on this symbol.
            cw_done_d         = 1'b1;
            cw_err_d          = 1'b0;
            cw_fail_d         = 1'b1;
            synd_frame_sync_d = 1'b1;
            symb_cnt_d        = CntW'(1);
          end else begin
            symb_cnt_d = symb_cnt_q + CntW'(1);
            if (symb_cnt_q == LastIdx) begin
              state_d = StWaitSynd;
            end
          end
        end
      end
      StWaitSynd: begin
        if (i_synd_ready) begin
          if (synd_zero) begin
            cw_done_d = 1'b1;
            cw_err_d  = 1'b0;
            cw_fail_d = 1'b0;
            state_d   = StDone;
          end else begin
            euclid_start_d = 1'b1;
            state_d        = StWaitEuclid;
          end
        end else if (timed_out) begin
          cw_done_d = 1'b1;
          cw_err_d  = 1'b0;
          cw_fail_d = 1'b1;
          state_d   = StDone;
        end
      end
      StWaitEuclid: begin
        if (i_euclid_ready || timed_out) begin
          cw_done_d = 1'b1;
          cw_err_d  = 1'b1;
          cw_fail_d = ~i_euclid_ready;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d != state_q) begin
      tmo_d = '0;
    end

    if (sync_in && (state_q inside {StWaitSynd, StWaitEuclid, StDone})) begin
      overrun_d = 1'b1;
    end
    if (i_clr_stat) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      state_q           <= StIdle;
      symb_cnt_q        <= '0;
      tmo_q             <= '0;
      synd_data_q       <= '0;
      synd_data_sync_q  <= 1'b0;
      synd_frame_sync_q <= 1'b0;
      euclid_start_q    <= 1'b0;
      cw_done_q         <= 1'b0;
      cw_err_q          <= 1'b0;
      cw_fail_q         <= 1'b0;
      overrun_q         <= 1'b0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      symb_cnt_q        <= symb_cnt_d;
      tmo_q             <= tmo_d;
      synd_data_q       <= synd_data_d;
      synd_data_sync_q  <= synd_data_sync_d;
      synd_frame_sync_q <= synd_frame_sync_d;
      euclid_start_q    <= euclid_start_d;
      cw_done_q         <= cw_done_d;
      cw_err_q          <= cw_err_d;
      cw_fail_q         <= cw_fail_d;
      overrun_q         <= overrun_d;
      busy_q            <= (state_d != StIdle);
    end
  end

  // Counters bump on the same edge that raises o_cw_done, so both are visible together.
  rs_dec_sat_counter #(
    .P_W(P_CNT_W)
  ) u_cw_cnt (
    .clk  (i_clk),
    .rst_n(i_resb),
    .clr  (i_clr_stat),
    .inc  (cw_done_d),
    .cnt  (o_cw_cnt)
  );

  rs_dec_sat_counter #(
    .P_W(P_CNT_W)
  ) u_err_cnt (
    .clk  (i_clk),
    .rst_n(i_resb),
    .clr  (i_clr_stat),
    .inc  (cw_done_d & (cw_err_d | cw_fail_d)),
    .cnt  (o_err_cnt)
  );

  assign o_synd_frame_sync = synd_frame_sync_q;
  assign o_synd_data       = synd_data_q;
  assign o_synd_data_sync  = synd_data_sync_q;
  assign o_euclid_start    = euclid_start_q;
  assign o_cw_done         = cw_done_q;
  assign o_cw_err          = cw_err_q;
  assign o_cw_fail         = cw_fail_q;
  assign o_busy            = busy_q;
  assign o_overrun         = overrun_q;

endmodule

// File: tb/tb_rs_dec_frame_scheduler.sv
// Scoreboard bench: the driver pushes expected forwards/starts/completions, a negedge
// monitor pops and compares them whenever the scheduler presents an output.
module tb_rs_dec_frame_scheduler;

  localparam int N   = 32;
  localparam int TMO = 64;
  localparam int CW  = 16;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       fs;
  } fwd_t;

  typedef struct {
    int   cyc;
    logic err;
    logic fail;
    int   cw;
    int   ec;
  } done_t;

  logic          i_clk = 1'b0;
  logic          i_resb = 1'b0;
  logic [7:0]    i_symb = '0;
  logic          i_symb_valid = 1'b0;
  logic          i_frame_sync = 1'b0;
  logic          i_synd_ready = 1'b0;
  logic [7:0]    i_s0 = '0, i_s1 = '0, i_s2 = '0, i_s3 = '0;
  logic          i_euclid_ready = 1'b0;
  logic          i_clr_stat = 1'b0;
  logic          o_synd_frame_sync, o_synd_data_sync, o_euclid_start;
  logic [7:0]    o_synd_data;
  logic          o_cw_done, o_cw_err, o_cw_fail, o_busy, o_overrun;
  logic [CW-1:0] o_cw_cnt, o_err_cnt;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    cw_m = 0;
  int    ec_m = 0;
  bit    ovr_m = 1'b0;
  fwd_t  fwd_q[$];
  done_t done_q[$];
  int    start_q[$];

  rs_dec_frame_scheduler #(
    .P_N_SYMB (N),
    .P_TIMEOUT(TMO),
    .P_CNT_W  (CW)
  ) dut (
    .i_clk            (i_clk),
    .i_resb           (i_resb),
    .i_symb           (i_symb),
    .i_symb_valid     (i_symb_valid),
    .i_frame_sync     (i_frame_sync),
    .o_synd_frame_sync(o_synd_frame_sync),
    .o_synd_data      (o_synd_data),
    .o_synd_data_sync (o_synd_data_sync),
    .i_synd_ready     (i_synd_ready),
    .i_s0             (i_s0),
    .i_s1             (i_s1),
    .i_s2             (i_s2),
    .i_s3             (i_s3),
    .o_euclid_start   (o_euclid_start),
    .i_euclid_ready   (i_euclid_ready),
    .o_cw_done        (o_cw_done),
    .o_cw_err         (o_cw_err),
    .o_cw_fail        (o_cw_fail),
    .o_busy           (o_busy),
    .o_overrun        (o_overrun),
    .i_clr_stat       (i_clr_stat),
    .o_cw_cnt         (o_cw_cnt),
    .o_err_cnt        (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  fwd_t  m_f;
  done_t m_d;
  int    m_s;

  always @(negedge i_clk) begin
    if (i_resb) begin
      if (o_synd_data_sync) begin
        chk("fwd_expected", int'(fwd_q.size() != 0), 1);
        if (fwd_q.size() != 0) begin
          m_f = fwd_q.pop_front();
          chk("fwd_cycle", cyc, m_f.cyc);
          chk("fwd_data", int'(o_synd_data), int'(m_f.data));
          chk("fwd_frame_sync", int'(o_synd_frame_sync), int'(m_f.fs));
        end
      end else if (o_synd_frame_sync) begin
        chk("frame_sync_without_data", int'(o_synd_data_sync), 1);
      end
      if (o_euclid_start) begin
        chk("start_expected", int'(start_q.size() != 0), 1);
        if (start_q.size() != 0) begin
          m_s = start_q.pop_front();
          chk("start_cycle", cyc, m_s);
        end
      end
      if (o_cw_done) begin
        chk("done_expected", int'(done_q.size() != 0), 1);
        if (done_q.size() != 0) begin
          m_d = done_q.pop_front();
          chk("done_cycle", cyc, m_d.cyc);
          chk("done_err", int'(o_cw_err), int'(m_d.err));
          chk("done_fail", int'(o_cw_fail), int'(m_d.fail));
          chk("done_cw_cnt", int'(o_cw_cnt), m_d.cw);
          chk("done_err_cnt", int'(o_err_cnt), m_d.ec);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit fs, input logic [7:0] d, input bit fwd);
    i_symb_valid = v;
    i_frame_sync = fs;
    i_symb       = d;
    if (v && fwd) fwd_q.push_back('{cyc + 1, d, fs});
    tick();
    i_symb_valid = 1'b0;
    i_frame_sync = 1'b0;
  endtask

  // Cycles outside COLLECT: random valid symbols (never with sync) must be dropped.
  task automatic idle(input int n);
    bit v;
    repeat (n) begin
      v = 1'($urandom_range(1, 0));
      drive(v, v ? 1'b0 : 1'($urandom_range(1, 0)), 8'($urandom), 1'b0);
    end
  endtask

  task automatic expect_done(input int c, input bit err, input bit fail);
    if (cw_m < (1 << CW) - 1) cw_m++;
    if ((err || fail) && ec_m < (1 << CW) - 1) ec_m++;
    done_q.push_back('{c, err, fail, cw_m, ec_m});
  endtask

  task automatic send_frame(input int n, input int gmin, input int gmax, input bit first);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gmax, gmin)) drive(1'b0, 1'($urandom_range(1, 0)),
                                                8'($urandom), 1'b0);
      drive(1'b1, first && (i == 0), 8'($urandom), 1'b1);
    end
  endtask

  task automatic truncate();
    expect_done(cyc + 1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'($urandom), 1'b1);
  endtask

  // Called on the first WAIT_SYND cycle; returns on the first IDLE cycle.
  task automatic finish_cw(input logic [31:0] synd, input int slat, input int elat,
                           input bit sto, input bit eto, input bit ovr);
    int e;
    e = cyc;
    if (sto) begin
      expect_done(e + TMO + 1, 1'b0, 1'b1);
      idle(TMO + 1);
    end else begin
      idle(slat);
      i_synd_ready = 1'b1;
      {i_s3, i_s2, i_s1, i_s0} = synd;
      if (synd == 32'h0) expect_done(cyc + 1, 1'b0, 1'b0);
      else start_q.push_back(cyc + 1);
      tick();
      i_synd_ready = 1'b0;
      {i_s3, i_s2, i_s1, i_s0} = 32'h0;
      if (synd != 32'h0) begin
        e = cyc;
        if (ovr) drive(1'b1, 1'b1, 8'($urandom), 1'b0);
        if (eto) begin
          expect_done(e + TMO + 1, 1'b1, 1'b1);
          idle(TMO + 1 - int'(ovr));
        end else begin
          idle(elat - int'(ovr));
          i_euclid_ready = 1'b1;
          expect_done(cyc + 1, 1'b1, 1'b0);
          tick();
          i_euclid_ready = 1'b0;
        end
      end
    end
    idle(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] synd;
    bit          sto, eto, ovr;
    int          g;

    #2;
    chk("rst_done", int'(o_cw_done), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_fwd", int'(o_synd_data_sync), 0);
    chk("rst_cw_cnt", int'(o_cw_cnt), 0);
    repeat (2) tick();
    i_resb = 1'b1;
    idle(2);

    // Clean codeword, syndromes 3 cycles after WAIT_SYND entry.
    send_frame(N, 0, 0, 1'b1);
    chk("busy_wait_synd", int'(o_busy), 1);
    finish_cw(32'h0, 3, 0, 1'b0, 1'b0, 1'b0);
    chk("idle_busy", int'(o_busy), 0);
    chk("clean_cw_cnt", int'(o_cw_cnt), 1);
    chk("clean_err_cnt", int'(o_err_cnt), 0);

    // Errored codeword, s1 = 0x5A, Euclid ready 10 cycles after start.
    send_frame(N, 0, 0, 1'b1);
    finish_cw(32'h0000_5A00, 2, 10, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("err_held", int'(o_cw_err), 1);
    chk("err_err_cnt", int'(o_err_cnt), 1);

    // Truncation after 20 symbols, then a full frame.
    send_frame(20, 0, 0, 1'b1);
    truncate();
    send_frame(N - 1, 0, 0, 1'b0);
    finish_cw(32'h0, TMO, 0, 1'b0, 1'b0, 1'b0);

    // Euclid timeout, then syndrome timeout.
    send_frame(N, 0, 0, 1'b1);
    finish_cw(32'h0100_0000, 1, 0, 1'b0, 1'b1, 1'b0);
    send_frame(N, 0, 0, 1'b1);
    finish_cw(32'h0, 0, 0, 1'b1, 1'b0, 1'b0);

    // Gapped 1-of-3 symbols, sync during WAIT_EUCLID, then clear statistics.
    chk("overrun_pre", int'(o_overrun), 0);
    send_frame(N, 2, 2, 1'b1);
    finish_cw(32'h0000_0007, 4, 8, 1'b0, 1'b0, 1'b1);
    chk("overrun_set", int'(o_overrun), 1);
    i_clr_stat = 1'b1;
    tick();
    i_clr_stat = 1'b0;
    cw_m = 0;
    ec_m = 0;
    chk("clr_overrun", int'(o_overrun), 0);
    chk("clr_cw_cnt", int'(o_cw_cnt), 0);
    chk("clr_err_cnt", int'(o_err_cnt), 0);

    // Errored codeword to set status flags, then reset mid-COLLECT.
    send_frame(N, 0, 0, 1'b1);
    finish_cw(32'h0000_0010, 0, 1, 1'b0, 1'b1, 1'b0);
    send_frame(10, 0, 1, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge i_clk);
    #1;
    i_resb = 1'b0;
    #1;
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_err", int'(o_cw_err), 0);
    chk("mid_rst_fail", int'(o_cw_fail), 0);
    chk("mid_rst_data", int'(o_synd_data), 0);
    chk("mid_rst_cw_cnt", int'(o_cw_cnt), 0);
    chk("mid_rst_err_cnt", int'(o_err_cnt), 0);
    chk("mid_rst_pending", int'(fwd_q.size() + done_q.size()), 0);
    cw_m = 0;
    ec_m = 0;
    repeat (2) tick();
    i_resb = 1'b1;
    idle(1);
    send_frame(N, 0, 0, 1'b1);
    finish_cw(32'h0, 5, 0, 1'b0, 1'b0, 1'b0);

    // Randomised codewords.
    for (int k = 0; k < 24; k++) begin
      g = $urandom_range(2, 0);
      if ($urandom_range(4, 0) == 0) begin
        send_frame($urandom_range(N - 1, 1), 0, g, 1'b1);
        truncate();
        send_frame(N - 1, 0, g, 1'b0);
      end else begin
        send_frame(N, 0, g, 1'b1);
      end
      synd = ($urandom_range(1, 0) == 0) ? 32'h0 : $urandom;
      sto  = ($urandom_range(9, 0) == 0);
      eto  = ($urandom_range(9, 0) == 0);
      ovr  = ($urandom_range(4, 0) == 0);
      if (!sto && synd != 32'h0 && ovr) ovr_m = 1'b1;
      finish_cw(synd, $urandom_range(TMO, 0), $urandom_range(TMO, 1), sto, eto, ovr);
      idle($urandom_range(3, 0));
    end

    idle(5);
    chk("end_fwd_queue", fwd_q.size(), 0);
    chk("end_done_queue", done_q.size(), 0);
    chk("end_start_queue", start_q.size(), 0);
    chk("end_overrun", int'(o_overrun), int'(ovr_m));
    chk("end_cw_cnt", int'(o_cw_cnt), cw_m);
    chk("end_err_cnt", int'(o_err_cnt), ec_m);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
